vga_rx_monitor: RTL and testbench

- Synthesizable VGA sink: samples hsync/vsync/rgb from a VGA source (e.g. the maze display pipeline), checks 640x480@60 timing, and re-derives the pixel stream with coordinates.
- Once locked, reports a per-frame pixel checksum and frame count.
- Used as an on-chip self-check and as the hardware capture end of the VGA link, on the 25 MHz pixel clock.

---
 rtl/vga_rx_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
// VGA sink: registers hsync/vsync/rgb, checks line/frame timing, locks onto the
// stream and reports visible pixels with coordinates plus a per-frame checksum.
module vga_rx_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [11:0] i_rgb,
    output logic        o_pix_valid,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic [11:0] o_rgb,
    output logic        o_sof,
    output logic        o_frame_done,
    output logic [31:0] o_frame_sum,
    output logic [15:0] o_frame_cnt,
    output logic        o_locked,
    output logic        o_err_pulse,
    output logic [3:0]  o_err_code,
    output logic [7:0]  o_err_cnt
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_VIS_LO = H_SYNC + H_BP;
    localparam int H_VIS_HI = H_VIS_LO + H_ACTIVE - 1;
    localparam int V_VIS_LO = V_SYNC + V_BP;
    localparam int V_VIS_HI = V_VIS_LO + V_ACTIVE - 1;

    typedef enum logic [1:0] {WAIT_VS, CHECK, LOCKED} state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (&v) ? v : v + 10'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    state_t      state;
    logic        hs_p0, vs_p0, hs_prev, vs_prev;
    logic [11:0] rgb_p0, rgb_p1;
    logic [9:0]  hcnt, vcnt, vs_lines;
    logic        first_line;
    logic [31:0] acc;
    logic        h_fall, h_rise, v_fall, v_rise;
    logic [10:0] hcnt_inc, vcnt_end;
    logic [3:0]  err;
    logic        vis_p1;
    logic [9:0]  x_p1, y_p1;

    // Stage p0: input capture plus previous sample for edge detection
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            hs_p0   <= 1'b1;
            vs_p0   <= 1'b1;
            hs_prev <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            hs_p0   <= i_hsync;
            vs_p0   <= i_vsync;
            hs_prev <= hs_p0;
            vs_prev <= vs_p0;
        end
    end

    always_ff @(posedge sys_clk) begin
        rgb_p0 <= i_rgb;
        rgb_p1 <= rgb_p0;
    end

    // Counters hold the position of the sample in rgb_p1, so edges seen at p0
    // compare against the count of the sample just before the edge.
    always_comb begin
        h_fall   = hs_prev & ~hs_p0;
        h_rise   = ~hs_prev & hs_p0;
        v_fall   = vs_prev & ~vs_p0;
        v_rise   = ~vs_prev & vs_p0;
        hcnt_inc = {1'b0, hcnt} + 11'd1;
        vcnt_end = {1'b0, vcnt} + {10'd0, h_fall};
        err[0]   = h_fall & ~first_line & (hcnt_inc != 11'(H_TOTAL));
        err[1]   = h_rise & (hcnt_inc != 11'(H_SYNC));
        err[2]   = v_fall & (vcnt_end != 11'(V_TOTAL));
        err[3]   = v_rise & (vs_lines != 10'(V_SYNC));
        vis_p1   = (hcnt >= 10'(H_VIS_LO)) && (hcnt <= 10'(H_VIS_HI)) &&
                   (vcnt >= 10'(V_VIS_LO)) && (vcnt <= 10'(V_VIS_HI));
        x_p1     = hcnt - 10'(H_VIS_LO);
        y_p1     = vcnt - 10'(V_VIS_LO);
    end

    // Stage p1: line, frame and vsync-width counters
    always_ff @(posedge sys_clk) begin
        if (rst || !i_enable) begin
            hcnt     <= '0;
            vcnt     <= '0;
            vs_lines <= '0;
        end else begin
            hcnt <= h_fall ? 10'd0 : sat_inc10(hcnt);
            if (v_fall) begin
                vcnt     <= {9'd0, h_fall};
                vs_lines <= {9'd0, h_fall};
            end else if (h_fall) begin
                vcnt <= sat_inc10(vcnt);
                if (!vs_p0)
                    vs_lines <= sat_inc10(vs_lines);
            end
        end
    end

    // Stage p2: lock FSM and registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= WAIT_VS;
            first_line   <= 1'b0;
            acc          <= '0;
            o_pix_valid  <= 1'b0;
            o_x          <= '0;
            o_y          <= '0;
            o_rgb        <= '0;
            o_sof        <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_sum  <= '0;
            o_frame_cnt  <= '0;
            o_locked     <= 1'b0;
            o_err_pulse  <= 1'b0;
            o_err_code   <= '0;
            o_err_cnt    <= '0;
        end else begin
            o_pix_valid  <= 1'b0;
            o_x          <= '0;
            o_y          <= '0;
            o_rgb        <= '0;
            o_sof        <= 1'b0;
            o_frame_done <= 1'b0;
            o_err_pulse  <= 1'b0;
            if (!i_enable) begin
                state      <= WAIT_VS;
                o_locked   <= 1'b0;
                first_line <= 1'b0;
            end else begin
                case (state)
                    WAIT_VS: begin
                        o_locked <= 1'b0;
                        if (v_fall) begin
                            state      <= CHECK;
                            acc        <= '0;
                            first_line <= 1'b1;
                        end
                    end
                    CHECK: begin
                        if (h_fall)
                            first_line <= 1'b0;
                        if (|err) begin
                            state <= WAIT_VS;
                        end else if (v_fall) begin
                            state      <= LOCKED;
                            o_locked   <= 1'b1;
                            acc        <= '0;
                            first_line <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        if (vis_p1) begin
                            o_pix_valid <= 1'b1;
                            o_x         <= x_p1;
                            o_y         <= y_p1;
                            o_rgb       <= rgb_p1;
                            o_sof       <= (x_p1 == 10'd0) && (y_p1 == 10'd0);
                        end
                        if (|err) begin
                            o_err_pulse <= 1'b1;
                            o_err_code  <= err;
                            o_err_cnt   <= sat_inc8(o_err_cnt);
                            o_locked    <= 1'b0;
                            state       <= WAIT_VS;
                        end else if (v_fall) begin
                            o_frame_done <= 1'b1;
                            o_frame_sum  <= acc;
                            o_frame_cnt  <= sat_inc16(o_frame_cnt);
                            acc          <= '0;
                        end else if (vis_p1) begin
                            acc <= acc + {20'd0, rgb_p1};
                        end
                    end
                    default: begin
                        state    <= WAIT_VS;
                        o_locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced 16x9 timing so that many
// whole frames (clean and deliberately corrupted) fit in a short run.
module tb_vga_rx_monitor;
    localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 2;
    localparam int VT = VA + VFP + VS + VBP;

    logic        clk = 1'b0;
    logic        rst, en, hs, vs;
    logic [11:0] rgb;
    logic        o_pix_valid, o_sof, o_frame_done, o_locked, o_err_pulse;
    logic [9:0]  o_x, o_y;
    logic [11:0] o_rgb;
    logic [31:0] o_frame_sum;
    logic [15:0] o_frame_cnt;
    logic [3:0]  o_err_code;
    logic [7:0]  o_err_cnt;

    int n_checks = 0;
    int n_err = 0;
    int done_cnt = 0, errp_cnt = 0, pv_cnt = 0, sof_cnt = 0, bad_pix = 0, bad_sof = 0;
    logic [31:0] last_sum = '0;
    logic [3:0]  last_code = '0;
    logic [11:0] last_rgb = '0;
    bit          pat_mode = 1'b0;

    always #20 clk = ~clk;

    vga_rx_monitor #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .sys_clk(clk), .rst(rst), .i_enable(en), .i_hsync(hs), .i_vsync(vs), .i_rgb(rgb),
        .o_pix_valid(o_pix_valid), .o_x(o_x), .o_y(o_y), .o_rgb(o_rgb), .o_sof(o_sof),
        .o_frame_done(o_frame_done), .o_frame_sum(o_frame_sum), .o_frame_cnt(o_frame_cnt),
        .o_locked(o_locked), .o_err_pulse(o_err_pulse), .o_err_code(o_err_code),
        .o_err_cnt(o_err_cnt)
    );

    function automatic logic [11:0] exp_pix(input logic [9:0] x, input logic [9:0] y, input bit mode);
        return mode ? {4'h0, y[3:0], x[3:0]} : 12'h00F;
    endfunction

    function automatic logic [63:0] ctl_bits();
        return {31'b0, o_pix_valid, o_sof, o_frame_done, o_locked, o_err_pulse,
                o_err_code, o_err_cnt, o_frame_cnt};
    endfunction

    function automatic logic [63:0] dat_bits();
        return {32'b0, o_x, o_y, o_rgb};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output event recorder, sampled on the inactive edge
    always @(negedge clk) begin
        if (o_frame_done) begin
            done_cnt <= done_cnt + 1;
            last_sum <= o_frame_sum;
        end
        if (o_err_pulse) begin
            errp_cnt  <= errp_cnt + 1;
            last_code <= o_err_code;
        end
        if (o_pix_valid) begin
            pv_cnt   <= pv_cnt + 1;
            last_rgb <= o_rgb;
            if (o_rgb !== exp_pix(o_x, o_y, pat_mode))
                bad_pix <= bad_pix + 1;
        end
        if (o_sof)
            sof_cnt <= sof_cnt + 1;
        if (o_sof !== (o_pix_valid && o_x == 10'd0 && o_y == 10'd0))
            bad_sof <= bad_sof + 1;
    end

    // One frame from active line 0; vsync switches at h=0 of its first sync line.
    task automatic gen_frame(input bit mode, input int ext_line, input int short_line,
                             input int vs_len, input int drop_line, input int rst_line,
                             input int en_line);
        bit rst_chk;
        rst_chk  = 1'b0;
        pat_mode = mode;
        for (int v = 0; v < VT; v++) begin
            if (v != drop_line) begin
                int len, hs_start, hs_w;
                len      = HT + ((v == ext_line) ? 1 : 0);
                hs_start = HA + HFP + ((v == ext_line) ? 1 : 0);
                hs_w     = (v == short_line) ? HS - 1 : HS;
                for (int h = 0; h < len; h++) begin
                    @(posedge clk);
                    #1;
                    if (rst_chk) begin
                        check("rst_mid_ctl", ctl_bits(), 64'd0);
                        check("rst_mid_dat", dat_bits(), 64'd0);
                        check("rst_mid_sum", {32'd0, o_frame_sum}, 64'd0);
                        rst_chk = 1'b0;
                    end
                    hs  = !(h >= hs_start && h < hs_start + hs_w);
                    vs  = !(v >= VA + VFP && v < VA + VFP + vs_len);
                    rgb = (h < HA && v < VA) ? (mode ? {4'h0, 4'(v), 4'(h)} : 12'h00F) : 12'h000;
                    rst = (v == rst_line && h == 3);
                    if (rst)
                        rst_chk = 1'b1;
                    en  = !(v == en_line && h < 10);
                end
            end
        end
    endtask

    task automatic clean(input bit mode);
        gen_frame(mode, -1, -1, VS, -1, -1, -1);
    endtask

    initial begin
        int d0, e0, p0, s0;
        rst = 1'b1; en = 1'b1; hs = 1'b1; vs = 1'b1; rgb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", ctl_bits(), 64'd0);
        check("reset_dat", dat_bits(), 64'd0);
        check("reset_sum", {32'd0, o_frame_sum}, 64'd0);
        rst = 1'b0;

        // Acquire: CHECK after 1st vsync fall, LOCKED after 2nd, report after 3rd
        d0 = done_cnt;
        clean(1'b0);
        check("f1_locked", {63'd0, o_locked}, 64'd0);
        clean(1'b0);
        check("f2_locked", {63'd0, o_locked}, 64'd1);
        check("f2_no_done", 64'(done_cnt - d0), 64'd0);
        clean(1'b0);
        check("f3_done", 64'(done_cnt - d0), 64'd1);
        check("f3_sum", {32'd0, last_sum}, 64'd480);
        check("f3_frame_cnt", {48'd0, o_frame_cnt}, 64'd1);
        check("f3_err_cnt", {56'd0, o_err_cnt}, 64'd0);

        // Coordinate pattern frame
        p0 = pv_cnt; s0 = sof_cnt;
        clean(1'b1);
        check("f4_pix_count", 64'(pv_cnt - p0), 64'd32);
        check("f4_sof_count", 64'(sof_cnt - s0), 64'd1);
        check("f4_last_rgb", {52'd0, last_rgb}, 64'h037);
        check("f4_sum", {32'd0, last_sum}, 64'd880);
        check("f4_frame_cnt", {48'd0, o_frame_cnt}, 64'd2);

        // Stretched line
        e0 = errp_cnt; d0 = done_cnt;
        gen_frame(1'b0, 2, -1, VS, -1, -1, -1);
        check("ext_pulses", 64'(errp_cnt - e0), 64'd1);
        check("ext_code_pulse", {60'd0, last_code}, 64'b0001);
        check("ext_code", {60'd0, o_err_code}, 64'b0001);
        check("ext_err_cnt", {56'd0, o_err_cnt}, 64'd1);
        check("ext_locked", {63'd0, o_locked}, 64'd0);
        check("ext_no_done", 64'(done_cnt - d0), 64'd0);
        clean(1'b0);
        check("ext_relock", {63'd0, o_locked}, 64'd1);
        check("ext_frame_cnt", {48'd0, o_frame_cnt}, 64'd2);

        // Narrow hsync
        e0 = errp_cnt;
        gen_frame(1'b0, -1, 1, VS, -1, -1, -1);
        check("hsw_pulses", 64'(errp_cnt - e0), 64'd1);
        check("hsw_code", {60'd0, o_err_code}, 64'b0010);
        check("hsw_err_cnt", {56'd0, o_err_cnt}, 64'd2);
        check("hsw_locked", {63'd0, o_locked}, 64'd0);
        clean(1'b0);
        check("hsw_relock", {63'd0, o_locked}, 64'd1);

        // Three-line vsync (frame itself completes before the vsync rise)
        gen_frame(1'b0, -1, -1, 3, -1, -1, -1);
        check("vsw_code", {60'd0, o_err_code}, 64'b1000);
        check("vsw_err_cnt", {56'd0, o_err_cnt}, 64'd3);
        check("vsw_frame_cnt", {48'd0, o_frame_cnt}, 64'd3);
        check("vsw_locked", {63'd0, o_locked}, 64'd0);
        clean(1'b0);
        clean(1'b0);
        check("vsw_relock", {63'd0, o_locked}, 64'd1);

        // Short frame: one front-porch line removed
        d0 = done_cnt;
        gen_frame(1'b0, -1, -1, VS, 4, -1, -1);
        check("frm_code", {60'd0, o_err_code}, 64'b0100);
        check("frm_err_cnt", {56'd0, o_err_cnt}, 64'd4);
        check("frm_no_done", 64'(done_cnt - d0), 64'd0);
        check("frm_frame_cnt", {48'd0, o_frame_cnt}, 64'd3);
        clean(1'b0);
        clean(1'b0);
        check("frm_relock", {63'd0, o_locked}, 64'd1);

        // Enable dropped for 10 clocks
        e0 = errp_cnt;
        gen_frame(1'b0, -1, -1, VS, -1, -1, 1);
        check("en_locked", {63'd0, o_locked}, 64'd0);
        check("en_frame_cnt", {48'd0, o_frame_cnt}, 64'd3);
        check("en_err_cnt", {56'd0, o_err_cnt}, 64'd4);
        check("en_err_code", {60'd0, o_err_code}, 64'b0100);
        check("en_frame_sum", {32'd0, o_frame_sum}, 64'd480);
        clean(1'b0);
        check("en_relock", {63'd0, o_locked}, 64'd1);
        clean(1'b0);
        check("en_frame_cnt2", {48'd0, o_frame_cnt}, 64'd4);
        check("en_no_err_pulse", 64'(errp_cnt - e0), 64'd0);

        // Reset in the middle of a locked frame
        gen_frame(1'b0, -1, -1, VS, -1, 2, -1);
        check("rst_locked", {63'd0, o_locked}, 64'd0);
        check("rst_frame_cnt", {48'd0, o_frame_cnt}, 64'd0);
        clean(1'b0);
        check("rst_relock", {63'd0, o_locked}, 64'd1);
        check("rst_err_cnt", {56'd0, o_err_cnt}, 64'd0);

        check("pix_values", 64'(bad_pix), 64'd0);
        check("sof_alignment", 64'(bad_sof), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
